decoder38_scan_ctrl: RTL

DECODER38_SCAN_CTRL -- requirements
Module: decoder38_scan_ctrl

---
 rtl/decoder38_scan_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/decoder38_scan_ctrl.sv
// ---------------------------------------------------------------------------
// decoder38_scan_ctrl
//   Drives the enable pins and select address of an external 3-to-8 decoder
//   ('138 style) so that the channels enabled in a mask are selected in turn.
//   Each channel is held for a programmable number of cycles (dwell).
//
//   Optional feature: define SCAN_BLANK_EN to insert one decoder-disabled
//   BLANK cycle between consecutive channels. Without it, the decoder stays
//   enabled and A changes on the cycle right after ch_done.
//
// Parameters
//   DWELL_W : width of the dwell count
//   CONT    : 1 = continuous scanning, 0 = one frame per start
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   scan request, sampled in IDLE
//   stop       in   stop request, honoured at end of the current channel
//   mask[7:0]  in   channel enable mask (bit n = channel n scanned)
//   dwell      in   cycles per channel (0 behaves as 1)
//   S1         out  decoder enable, active high
//   S2, S3     out  decoder enables, active low
//   A[2:0]     out  decoder select address
//   busy       out  high whenever not IDLE
//   ch_done    out  pulse on the last dwell cycle of each channel
//   frame_done out  pulse with ch_done of the highest enabled channel
// ---------------------------------------------------------------------------
module decoder38_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int CONT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               S1,
  output logic               S2,
  output logic               S3,
  output logic [2:0]         A,
  output logic               busy,
  output logic               ch_done,
  output logic               frame_done
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif

  state_t             state, state_n;
  logic [2:0]         a_q, a_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [7:0]         mask_l, mask_l_n;
  logic [DWELL_W-1:0] dwell_l, dwell_l_n;
  logic               stop_pend, stop_pend_n;
  logic [2:0]         nxt;
`ifdef SCAN_BLANK_EN
  logic [2:0]         a_nxt, a_nxt_n;
`endif

  logic stop_eff, last, frame_end, in_dwell;

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest_ch = 3'(i);
  endfunction

  function automatic logic [2:0] highest_ch(input logic [7:0] m);
    highest_ch = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) highest_ch = 3'(i);
  endfunction

  // Priority search upward from the current channel; the 3-bit add wraps
  // 7->0, and k=8 lands back on the current channel (single-channel mask).
  function automatic logic [2:0] next_ch(input logic [2:0] a, input logic [7:0] m);
    logic [2:0] idx;
    logic       found;
    next_ch = a;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = a + 3'(k);
      if (!found && m[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [DWELL_W-1:0] load_cnt(input logic [DWELL_W-1:0] d);
    load_cnt = (d == '0) ? DWELL_W'(1) : d;
  endfunction

  assign in_dwell  = (state == DWELL);
  assign stop_eff  = stop_pend | stop;
  assign last      = (cnt == DWELL_W'(1));
  assign frame_end = (a_q == highest_ch(mask_l));

  always_comb begin
    state_n     = state;
    a_n         = a_q;
    cnt_n       = cnt;
    mask_l_n    = mask_l;
    dwell_l_n   = dwell_l;
    stop_pend_n = stop_pend;
    nxt         = a_q;
`ifdef SCAN_BLANK_EN
    a_nxt_n     = a_nxt;
`endif
    case (state)
      IDLE: begin
        a_n         = 3'd0;
        stop_pend_n = 1'b0;
        if (start && !stop && (mask != 8'd0)) begin
          mask_l_n  = mask;
          dwell_l_n = dwell;
          a_n       = lowest_ch(mask);
          cnt_n     = load_cnt(dwell);
          state_n   = DWELL;
        end
      end
      DWELL: begin
        stop_pend_n = stop_eff;
        if (!last) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (stop_eff) begin
          state_n     = IDLE;
          a_n         = 3'd0;
          stop_pend_n = 1'b0;
        end else begin
          if (frame_end) begin
            // Frame boundary: new mask/dwell take effect only here.
            mask_l_n  = mask;
            dwell_l_n = dwell;
            nxt       = lowest_ch(mask);
            cnt_n     = load_cnt(dwell);
          end else begin
            nxt   = next_ch(a_q, mask_l);
            cnt_n = load_cnt(dwell_l);
          end
          if (frame_end && ((CONT == 0) || (mask == 8'd0))) begin
            state_n = IDLE;
            a_n     = 3'd0;
          end else begin
`ifdef SCAN_BLANK_EN
            // A keeps the finished channel through the blank cycle.
            state_n = BLANK;
            a_nxt_n = nxt;
`else
            a_n     = nxt;
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        a_n     = a_nxt;
        state_n = DWELL;
      end
`endif
      default: begin
        state_n = IDLE;
        a_n     = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= 3'd0;
      cnt       <= '0;
      mask_l    <= 8'd0;
      dwell_l   <= '0;
      stop_pend <= 1'b0;
`ifdef SCAN_BLANK_EN
      a_nxt     <= 3'd0;
`endif
    end else begin
      state     <= state_n;
      a_q       <= a_n;
      cnt       <= cnt_n;
      mask_l    <= mask_l_n;
      dwell_l   <= dwell_l_n;
      stop_pend <= stop_pend_n;
`ifdef SCAN_BLANK_EN
      a_nxt     <= a_nxt_n;
`endif
    end
  end

  assign S1         = in_dwell;
  assign S2         = ~in_dwell;
  assign S3         = ~in_dwell;
  assign A          = a_q;
  assign busy       = (state != IDLE);
  assign ch_done    = in_dwell && last;
  assign frame_done = in_dwell && last && frame_end;

endmodule
